// File: rtl/dbus_decoder.sv
// rtl/dbus_decoder.sv - data-bus address decoder and in-order read response router
//
// Purpose:
//   Routes each LSU read/write to T0 (data RAM), T1 (peripherals) or an
//   internal error responder. Outstanding reads are tracked in issue order,
//   and read data is steered back combinationally from the head of that queue.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   h_*                 host (LSU) request/response side
//   t0_*, t1_*          target request/response sides
//   decode_error        one-cycle pulse after an unmapped access is accepted
//   stray_resp          one-cycle pulse after a target response nobody waits for
module dbus_decoder #(
  parameter logic [31:0] T0_BASE         = 32'h0000_0000,
  parameter logic [31:0] T0_MASK         = 32'hFFFF_0000,
  parameter logic [31:0] T1_BASE         = 32'h8000_0000,
  parameter logic [31:0] T1_MASK         = 32'hF000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_READDATA    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        h_read,
  input  logic        h_write,
  input  logic [31:0] h_address,
  input  logic [31:0] h_writedata,
  input  logic [3:0]  h_byte_enable,
  output logic        h_waitrequest,
  output logic [31:0] h_readdata,
  output logic        h_readdatavalid,

  output logic        t0_read,
  output logic        t0_write,
  output logic [31:0] t0_address,
  output logic [31:0] t0_writedata,
  output logic [3:0]  t0_byte_enable,
  input  logic        t0_waitrequest,
  input  logic [31:0] t0_readdata,
  input  logic        t0_readdatavalid,

  output logic        t1_read,
  output logic        t1_write,
  output logic [31:0] t1_address,
  output logic [31:0] t1_writedata,
  output logic [3:0]  t1_byte_enable,
  input  logic        t1_waitrequest,
  input  logic [31:0] t1_readdata,
  input  logic        t1_readdatavalid,

  output logic        decode_error,
  output logic        stray_resp
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ID_T0  = 2'd0,
    ID_T1  = 2'd1,
    ID_ERR = 2'd2
  } tgt_id_t;

  tgt_id_t       r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  tgt_id_t       r_tail_id;
  logic          r_err_valid;
  logic          r_decode_error;
  logic          r_stray_resp;

  tgt_id_t       w_sel;
  tgt_id_t       w_head;
  logic          w_cnt_nz;
  logic          w_blk;
  logic          w_rd_accept;
  logic          w_wr_accept;
  logic          w_stray;

  // T0 wins when both windows match.
  always_comb begin
    w_sel = ID_ERR;
    if ((h_address & T0_MASK) == T0_BASE)
      w_sel = ID_T0;
    else if ((h_address & T1_MASK) == T1_BASE)
      w_sel = ID_T1;
  end

  assign w_head   = r_fifo[r_rd_ptr];
  assign w_cnt_nz = |r_cnt;

  // A read may only join the queue behind reads to the same target, so every
  // target returns its data strictly in order relative to the others.
  assign w_blk = h_read & ((r_cnt == CNT_FULL) | (w_cnt_nz & (r_tail_id != w_sel)));

  assign t0_read  = h_read & (w_sel == ID_T0) & ~w_blk;
  assign t1_read  = h_read & (w_sel == ID_T1) & ~w_blk;
  assign t0_write = h_write & ~h_read & (w_sel == ID_T0);
  assign t1_write = h_write & ~h_read & (w_sel == ID_T1);

  assign t0_address     = h_address;
  assign t0_writedata   = h_writedata;
  assign t0_byte_enable = h_byte_enable;
  assign t1_address     = h_address;
  assign t1_writedata   = h_writedata;
  assign t1_byte_enable = h_byte_enable;

  // The error responder never stalls.
  assign h_waitrequest = w_blk
                       | ((w_sel == ID_T0) & (h_read | h_write) & t0_waitrequest)
                       | ((w_sel == ID_T1) & (h_read | h_write) & t1_waitrequest);

  assign w_rd_accept = h_read & ~h_waitrequest;
  assign w_wr_accept = h_write & ~h_read & ~h_waitrequest;

  // Response path is purely combinational so target latency is not increased.
  always_comb begin
    h_readdatavalid = 1'b0;
    h_readdata      = ERR_READDATA;
    case (w_head)
      ID_T0: begin
        h_readdatavalid = w_cnt_nz & t0_readdatavalid;
        h_readdata      = t0_readdata;
      end
      ID_T1: begin
        h_readdatavalid = w_cnt_nz & t1_readdatavalid;
        h_readdata      = t1_readdata;
      end
      default: begin
        h_readdatavalid = w_cnt_nz & r_err_valid;
        h_readdata      = ERR_READDATA;
      end
    endcase
  end

  assign w_stray = (t0_readdatavalid & (~w_cnt_nz | (w_head != ID_T0)))
                 | (t1_readdatavalid & (~w_cnt_nz | (w_head != ID_T1)));

  // Queue storage carries no reset; validity is defined solely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_rd_accept)
      r_fifo[r_wr_ptr] <= w_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_tail_id      <= ID_T0;
      r_err_valid    <= 1'b0;
      r_decode_error <= 1'b0;
      r_stray_resp   <= 1'b0;
    end else begin
      if (w_rd_accept) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_tail_id <= w_sel;
      end
      if (h_readdatavalid)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_rd_accept, h_readdatavalid})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // ERR reads only queue behind other ERR reads, each answered one cycle
      // after acceptance, so a single flag is enough.
      r_err_valid    <= w_rd_accept & (w_sel == ID_ERR);
      r_decode_error <= (w_rd_accept | w_wr_accept) & (w_sel == ID_ERR);
      r_stray_resp   <= w_stray;
    end
  end

  assign decode_error = r_decode_error;
  assign stray_resp   = r_stray_resp;

endmodule
